// File: rtl/l1d_axi_refill_bridge_pkg.sv
// Shared types and widths for the L1D AXI refill bridge.
// The MSHR id width is common to the request, AR, R and B channels.
package l1d_package;

    localparam int L1D_MSHR_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DELIVER = 2'd2
    } rfsm_e;

    // A counter for a 1-entry space still needs one bit to exist.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l1d_line_assembler.sv
// R-channel line assembler: collects one non-interleaved burst into a line
// buffer, then presents the line for exactly one cycle.
module l1d_line_assembler
    import l1d_package::*;
#(
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_rvalid,
    input  logic [DATA_W-1:0]                      i_rdata,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]           i_rid,
    input  logic                                   i_rlast,
    output logic                                   o_rready,
    output logic                                   o_refill_en,
    output logic [L1D_MSHR_ID_WIDTH-1:0]           o_refill_id,
    output logic [DATA_W*LINE_BEATS-1:0]           o_refill_data
);

    localparam int BEAT_W = cnt_w(LINE_BEATS);

    rfsm_e                                  r_state;
    logic [BEAT_W-1:0]                      r_beat_cnt;
    logic [L1D_MSHR_ID_WIDTH-1:0]           r_id;
    logic                                   r_refill_en;
    logic [LINE_BEATS-1:0][DATA_W-1:0]      r_line;

    logic                                   w_beat;

    assign w_beat = i_rvalid && (r_state != DELIVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_id        <= '0;
            r_refill_en <= 1'b0;
        end else begin
            r_refill_en <= 1'b0;
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_beat) begin
                        if (r_state == IDLE)
                            r_id <= i_rid;
                        if (i_rlast) begin
                            r_state     <= DELIVER;
                            r_beat_cnt  <= '0;
                            r_refill_en <= 1'b1;
                        end else begin
                            // Wraps naturally; an over-long burst overwrites from slot 0.
                            r_state    <= COLLECT;
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(LINE_BEATS > 1);
                        end
                    end
                end
                DELIVER: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line data is deliberately not reset; slots a short burst skips keep old contents.
    always_ff @(posedge clk) begin
        if (w_beat)
            r_line[r_beat_cnt] <= i_rdata;
    end

    assign o_rready      = (r_state != DELIVER);
    assign o_refill_en   = r_refill_en;
    assign o_refill_id   = r_id;
    assign o_refill_data = r_line;

endmodule

// File: rtl/l1d_axi_refill_bridge.sv
// L1D miss refill bridge: MSHR requests -> AXI AR, R bursts -> refill lines, B -> evict done.
// Define L1D_AXI_RESP_ERR_EN to add the sticky axi_err response-error flag.
module l1d_axi_refill_bridge
    import l1d_package::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int LINE_BEATS = 4,
    parameter int MAX_OUT    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   downstream_req_vld,
    output logic                                   downstream_req_rdy,
    input  logic [ADDR_W-1:0]                      downstream_req_addr,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]           downstream_req_id,
    output logic                                   axi_arvalid,
    input  logic                                   axi_arready,
    output logic [ADDR_W-1:0]                      axi_araddr,
    output logic [L1D_MSHR_ID_WIDTH-1:0]           axi_arid,
    output logic [2:0]                             axi_arsize,
    output logic [7:0]                             axi_arlen,
    input  logic                                   axi_rvalid,
    output logic                                   axi_rready,
    input  logic [DATA_W-1:0]                      axi_rdata,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]           axi_rid,
    input  logic [1:0]                             axi_rresp,
    input  logic                                   axi_rlast,
    output logic                                   refill_en,
    output logic [L1D_MSHR_ID_WIDTH-1:0]           refill_id,
    output logic [DATA_W*LINE_BEATS-1:0]           refill_data,
    input  logic                                   axi_bvalid,
    output logic                                   axi_bready,
    input  logic [L1D_MSHR_ID_WIDTH-1:0]           axi_bid,
    input  logic [1:0]                             axi_bresp,
    output logic                                   evict_done_en,
    output logic [L1D_MSHR_ID_WIDTH-1:0]           evict_done_id
`ifdef L1D_AXI_RESP_ERR_EN
    ,
    output logic                                   axi_err
`endif
);

    localparam int LINE_W     = DATA_W * LINE_BEATS;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int CNT_W      = $clog2(MAX_OUT + 1);

    logic                                   r_ar_full;
    logic [ADDR_W-1:0]                      r_ar_addr;
    logic [L1D_MSHR_ID_WIDTH-1:0]           r_ar_id;
    logic [CNT_W-1:0]                       r_out_cnt;
    logic                                   r_evict_en;
    logic [L1D_MSHR_ID_WIDTH-1:0]           r_evict_id;

    logic                                   w_accept;
    logic                                   w_refill_en;

    // A full entry that is handshaking this cycle can reload in the same cycle.
    assign downstream_req_rdy = (!r_ar_full || axi_arready) &&
                                (r_out_cnt < CNT_W'(MAX_OUT));
    assign w_accept = downstream_req_vld && downstream_req_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar_full <= 1'b0;
            r_ar_addr <= '0;
            r_ar_id   <= '0;
        end else if (w_accept) begin
            r_ar_full <= 1'b1;
            r_ar_addr <= downstream_req_addr;
            r_ar_id   <= downstream_req_id;
        end else if (axi_arready) begin
            r_ar_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_accept, w_refill_en})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= (r_out_cnt != '0) ? r_out_cnt - 1'b1 : r_out_cnt;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    assign axi_arvalid = r_ar_full;
    assign axi_araddr  = r_ar_addr & ~ADDR_W'(LINE_BYTES - 1);
    assign axi_arid    = r_ar_id;
    assign axi_arsize  = 3'($clog2(DATA_W / 8));
    assign axi_arlen   = 8'(LINE_BEATS - 1);

    l1d_line_assembler #(
        .DATA_W     (DATA_W),
        .LINE_BEATS (LINE_BEATS)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .i_rvalid      (axi_rvalid),
        .i_rdata       (axi_rdata),
        .i_rid         (axi_rid),
        .i_rlast       (axi_rlast),
        .o_rready      (axi_rready),
        .o_refill_en   (w_refill_en),
        .o_refill_id   (refill_id),
        .o_refill_data (refill_data)
    );

    assign refill_en = w_refill_en;

    // B is always accepted, so every bvalid cycle is a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evict_en <= 1'b0;
            r_evict_id <= '0;
        end else begin
            r_evict_en <= axi_bvalid;
            r_evict_id <= axi_bid;
        end
    end

    assign axi_bready    = 1'b1;
    assign evict_done_en = r_evict_en;
    assign evict_done_id = r_evict_id;

`ifdef L1D_AXI_RESP_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if ((axi_rvalid && axi_rready && axi_rresp != 2'b00) ||
                 (axi_bvalid && axi_bresp != 2'b00))
            r_err <= 1'b1;
    end

    assign axi_err = r_err;
`else
    logic w_unused_resp;
    assign w_unused_resp = ^{axi_rresp, axi_bresp};
`endif

endmodule
